// File: rtl/pet_pkg.sv
// Shared types and constants for the pet button-to-command arbiter.
package pet_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_SLEEP = 3'd1,
        CMD_AWAKE = 3'd2,
        CMD_FEED  = 3'd3,
        CMD_PLAY  = 3'd4
    } cmd_code_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_LOCKOUT    = 2'd2,
        ST_TEST_COUNT = 2'd3
    } arb_state_t;

    localparam int BTN_W     = 5;
    localparam int BTN_SLEEP = 0;
    localparam int BTN_AWAKE = 1;
    localparam int BTN_FEED  = 2;
    localparam int BTN_PLAY  = 3;
    localparam int BTN_TEST  = 4;

    // Test selector values follow the central FSM's state order.
    localparam logic [3:0] SEL_IDLE   = 4'd1;
    localparam logic [3:0] SEL_SLEEP  = 4'd2;
    localparam logic [3:0] SEL_AWAKE  = 4'd3;
    localparam logic [3:0] SEL_HUNGRY = 4'd4;
    localparam logic [3:0] SEL_EAT    = 4'd5;
    localparam logic [3:0] SEL_PLAY   = 4'd6;
    localparam logic [3:0] SEL_TIRED  = 4'd7;
    localparam logic [3:0] SEL_SICK   = 4'd8;
    localparam logic [3:0] SEL_DEATH  = 4'd9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Fixed priority AWAKE > SLEEP > FEED > PLAY.
    function automatic cmd_code_t pick_cmd(input logic [3:0] press);
        if (press[BTN_AWAKE]) begin
            return CMD_AWAKE;
        end else if (press[BTN_SLEEP]) begin
            return CMD_SLEEP;
        end else if (press[BTN_FEED]) begin
            return CMD_FEED;
        end else if (press[BTN_PLAY]) begin
            return CMD_PLAY;
        end else begin
            return CMD_NONE;
        end
    endfunction

endpackage

// File: rtl/pet_edge_detect.sv
// W-bit rising-edge detector; history resets high so levels held through reset never fire.
module pet_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_r;

    // Previous-level history, updated every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r <= {W{1'b1}};
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;

endmodule

// File: rtl/pet_cmd_arbiter.sv
// Converts button presses into single handshaked commands with lockout, and runs the test selector.
module pet_cmd_arbiter
    import pet_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 2500000,
    parameter int TEST_WINDOW    = 100000000,
    parameter int MAX_SEL        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep,
    input  logic       btn_awake,
    input  logic       btn_feed,
    input  logic       btn_play,
    input  logic       btn_test,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       test_active,
    output logic [3:0] test_sel,
    output logic       test_sel_valid,
    output logic       busy
);

    localparam int CNT_W = $clog2(max_int(LOCKOUT_CYCLES, TEST_WINDOW) + 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(TEST_WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       SEL_MAX   = 4'(MAX_SEL);

    logic [BTN_W-1:0] btn_s;
    logic [BTN_W-1:0] press_s;
    arb_state_t       state_r;
    cmd_code_t        cmd_code_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cmd_valid_r;
    logic             test_active_r;
    logic [3:0]       test_sel_r;
    logic             test_sel_valid_r;
    logic             busy_r;

    assign btn_s = {btn_test, btn_play, btn_feed, btn_awake, btn_sleep};

    pet_edge_detect #(.W(BTN_W)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_s),
        .rise  (press_s)
    );

    // Arbiter FSM; every output is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            cmd_code_r       <= CMD_NONE;
            cnt_r            <= CNT_ZERO;
            cmd_valid_r      <= 1'b0;
            test_active_r    <= 1'b0;
            test_sel_r       <= 4'd0;
            test_sel_valid_r <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            test_sel_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (press_s[BTN_TEST]) begin
                        state_r       <= ST_TEST_COUNT;
                        test_sel_r    <= 4'd0;
                        test_active_r <= 1'b1;
                        cnt_r         <= WIN_LOAD;
                        busy_r        <= 1'b1;
                    end else if (|press_s[BTN_PLAY:BTN_SLEEP]) begin
                        state_r     <= ST_ISSUE;
                        cmd_code_r  <= pick_cmd(press_s[BTN_PLAY:BTN_SLEEP]);
                        cmd_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state_r     <= ST_LOCKOUT;
                        cmd_code_r  <= CMD_NONE;
                        cmd_valid_r <= 1'b0;
                        cnt_r       <= LOCK_LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_TEST_COUNT: begin
                    // Test press outranks awake, which outranks play, which outranks the timeout.
                    if (press_s[BTN_TEST] && (test_sel_r != 4'd0)) begin
                        state_r          <= ST_LOCKOUT;
                        test_active_r    <= 1'b0;
                        test_sel_valid_r <= 1'b1;
                        cnt_r            <= LOCK_LOAD;
                    end else if (press_s[BTN_TEST] || press_s[BTN_AWAKE]
                                 || (!press_s[BTN_PLAY] && (cnt_r == CNT_ZERO))) begin
                        state_r       <= ST_IDLE;
                        test_active_r <= 1'b0;
                        test_sel_r    <= 4'd0;
                        cnt_r         <= CNT_ZERO;
                        busy_r        <= 1'b0;
                    end else if (press_s[BTN_PLAY]) begin
                        test_sel_r <= (test_sel_r == SEL_MAX) ? SEL_IDLE : test_sel_r + 4'd1;
                        cnt_r      <= WIN_LOAD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cmd_code_r    <= CMD_NONE;
                    cmd_valid_r   <= 1'b0;
                    test_active_r <= 1'b0;
                    cnt_r         <= CNT_ZERO;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid      = cmd_valid_r;
    assign cmd_code       = cmd_code_r;
    assign test_active    = test_active_r;
    assign test_sel       = test_sel_r;
    assign test_sel_valid = test_sel_valid_r;
    assign busy           = busy_r;

endmodule
